// File: rtl/ram_block_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_block_reader                                                |
// | Purpose  : Sequential dual-port RAM read master; packs even/odd bytes into |
// |            16-bit beats on a valid/ready stream through a 4-entry FIFO.    |
// | Option   : RAM_READER_CHECKSUM_EN builds a running 16-bit beat checksum.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ram_block_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0]    length,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   addr_a,
    output logic [ADDR_WIDTH-1:0]   addr_b,
    output logic                    we_a,
    output logic                    we_b,
    input  logic [DATA_WIDTH-1:0]   q_a,
    input  logic [DATA_WIDTH-1:0]   q_b,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [1:0]              out_keep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             checksum
);

    localparam int C_FIFO_DEPTH = 4;
    localparam int C_BEAT_W     = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [ADDR_WIDTH-1:0]  r_addr_a;
    logic [ADDR_WIDTH-1:0]  r_addr_b;
    logic                   r_p1_vld;
    logic                   r_p1_tail;
    logic                   r_p2_vld;
    logic                   r_p2_tail;
    logic [C_BEAT_W-1:0]    r_fifo_data [C_FIFO_DEPTH];
    logic [1:0]             r_fifo_keep [C_FIFO_DEPTH];
    logic [1:0]             r_wr_ptr;
    logic [1:0]             r_rd_ptr;
    logic [2:0]             r_count;

    logic                   w_accept;
    logic                   w_credit;
    logic                   w_issue_first;
    logic                   w_issue_more;
    logic                   w_issue;
    logic [ADDR_WIDTH-1:0]  w_issue_addr;
    logic [LEN_WIDTH-1:0]   w_issue_rem;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drained;

    // Requests in the two-stage RAM pipeline count against FIFO space, so a
    // beat always has a slot waiting for it when its data returns.
    assign w_accept      = (r_state == ST_IDLE) && start;
    assign w_credit      = (r_count + 3'(r_p1_vld) + 3'(r_p2_vld)) < 3'(C_FIFO_DEPTH);
    assign w_issue_first = w_accept && (length != '0);
    assign w_issue_more  = (r_state == ST_ISSUE) && (r_remaining != '0) && w_credit;
    assign w_issue       = w_issue_first || w_issue_more;
    assign w_issue_addr  = w_issue_first ? base_addr : r_ptr;
    assign w_issue_rem   = w_issue_first ? length : r_remaining;
    assign w_push        = r_p2_vld;
    assign w_pop         = (r_count != 3'd0) && out_ready;
    assign w_drained     = !r_p1_vld && !r_p2_vld &&
                           ((r_count == 3'd0) || ((r_count == 3'd1) && w_pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_remaining == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_credit && (r_remaining <= LEN_WIDTH'(2))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_p1_vld    <= 1'b0;
            r_p1_tail   <= 1'b0;
            r_p2_vld    <= 1'b0;
            r_p2_tail   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_keep[i] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_addr_a    <= w_issue_addr;
                r_addr_b    <= w_issue_addr + ADDR_WIDTH'(1);
                r_ptr       <= w_issue_addr + ADDR_WIDTH'(2);
                r_remaining <= (w_issue_rem >= LEN_WIDTH'(2)) ?
                               (w_issue_rem - LEN_WIDTH'(2)) : '0;
            end
            r_p1_vld  <= w_issue;
            r_p1_tail <= w_issue && (w_issue_rem == LEN_WIDTH'(1));
            r_p2_vld  <= r_p1_vld;
            r_p2_tail <= r_p1_tail;

            // An odd tail carries only the even byte; the odd lane is zero-padded.
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= {q_a, (r_p2_tail ? '0 : q_b)};
                r_fifo_keep[r_wr_ptr] <= r_p2_tail ? 2'b10 : 2'b11;
                r_wr_ptr              <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_FINISH);
    assign addr_a    = r_addr_a;
    assign addr_b    = r_addr_b;
    assign we_a      = 1'b0;
    assign we_b      = 1'b0;
    assign out_valid = (r_count != 3'd0);
    assign out_data  = r_fifo_data[r_rd_ptr];
    assign out_keep  = r_fifo_keep[r_rd_ptr];

`ifdef RAM_READER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (out_valid && out_ready) begin
            r_checksum <= r_checksum + 16'(out_data);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_block_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_block_reader                                             |
// | Purpose  : Scoreboard bench for ram_block_reader with a behavioural RAM.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ram_block_reader;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 11;
    localparam int MEM_SIZE = 1 << AW;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, we_a, we_b, out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] q_a, q_b;
    logic [15:0]   out_data;
    logic [1:0]    out_keep;
    logic [15:0]   checksum;

    ram_block_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .addr_a(addr_a), .addr_b(addr_b),
        .we_a(we_a), .we_b(we_b), .q_a(q_a), .q_b(q_b), .out_data(out_data),
        .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [MEM_SIZE];
    always @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom % 2);
        endcase
    end

    int          n_checks = 0;
    int          n_fail = 0;
    beat_t       exp_q[$];
    logic [15:0] exp_sum;
    int          c0 = 0;
    bit          first_pending = 0;
    int          last_hs_cyc = 0;
    int          beats_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: stability during stalls, first-beat latency, scoreboard pops.
    bit          stall_prev = 0;
    logic [15:0] stall_data;
    logic [1:0]  stall_keep;
    always @(negedge clk) begin
        beat_t b;
        if (reset_n) begin
            if (stall_prev && out_valid) begin
                check("stable_data", 32'(out_data), 32'(stall_data));
                check("stable_keep", 32'(out_keep), 32'(stall_keep));
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_keep = out_keep;
            if (first_pending && out_valid) begin
                check("first_beat_latency", 32'(cyc - c0), 32'd3);
                first_pending = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(b.data));
                    check("beat_keep", 32'(out_keep), 32'(b.keep));
                end
                last_hs_cyc = cyc;
                beats_seen++;
            end
        end else begin
            stall_prev = 0;
        end
    end

    function automatic logic [15:0] exp_checksum();
`ifdef RAM_READER_CHECKSUM_EN
        return exp_sum;
`else
        return 16'h0000;
`endif
    endfunction

    // Reference model: walk the byte region in pairs, wrapping addresses.
    task automatic start_xfer(input int base, input int len);
        beat_t b;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(base);
        length    = LW'(len);
        c0        = cyc;
        exp_sum   = '0;
        for (int i = 0; i < len; i += 2) begin
            b.data[15:8] = mem[(base + i) % MEM_SIZE];
            b.data[7:0]  = (i + 1 < len) ? mem[(base + i + 1) % MEM_SIZE] : 8'h00;
            b.keep       = (i + 1 < len) ? 2'b11 : 2'b10;
            exp_q.push_back(b);
            exp_sum = exp_sum + b.data;
        end
        first_pending = (len != 0);
        beats_seen    = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int len);
        int budget = 4 * len + 40;
        bit got = 0;
        bit seen_activity = 0;
        int dcyc = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (k == 0 && len != 0) check("busy_after_start", 32'(busy), 32'd1);
            if (k == 4 && len >= 20) begin
                start = 1'b1; base_addr = AW'(5); length = LW'(3);
            end
            if (k == 5 && len >= 20) start = 1'b0;
            if (done) begin
                got  = 1;
                dcyc = cyc;
            end else if (busy || out_valid) begin
                seen_activity = 1;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            if (len == 0) begin
                check("zero_len_done_cycle", 32'(dcyc - c0), 32'd1);
                check("zero_len_no_activity", 32'(seen_activity), 32'd0);
            end else begin
                check("done_after_last_hs", 32'(dcyc - last_hs_cyc), 32'd1);
            end
            check("busy_low_at_done", 32'(busy), 32'd0);
            check("beats_outstanding", 32'(exp_q.size()), 32'd0);
            check("checksum_at_done", 32'(checksum), 32'(exp_checksum()));
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_no_valid", 32'(out_valid), 32'd0);
        end
        exp_q.delete();
        first_pending = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_keep"},  32'(out_keep),  32'd0);
        check({tag, "_addr_a"},    32'(addr_a),    32'd0);
        check({tag, "_addr_b"},    32'(addr_b),    32'd0);
        check({tag, "_we"},        32'({we_a, we_b}), 32'd0);
        check({tag, "_checksum"},  32'(checksum),  32'd0);
    endtask

    initial begin
        string msg = "This RAM module can read and write.";
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;
        for (int i = 0; i < msg.len(); i++) mem[i] = msg[i];

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1'b1;

        // Full-rate and throttled reads of the text block
        rdy_mode = 0;
        start_xfer(0, 35);
        wait_done(35);
        rdy_mode = 1;
        start_xfer(0, 35);
        wait_done(35);

        // Address wrap
        rdy_mode = 0;
        mem[1023] = 8'hAA; mem[0] = 8'hBB; mem[1] = 8'hCC; mem[2] = 8'hDD;
        start_xfer(1023, 4);
        wait_done(4);
`ifdef RAM_READER_CHECKSUM_EN
        check("wrap_checksum", 32'(checksum), 32'h7798);
`else
        check("wrap_checksum", 32'(checksum), 32'h0000);
`endif
        mem[0] = 8'h54; mem[1] = 8'h68; mem[2] = 8'h69; mem[1023] = 8'h00;

        // Zero length
        start_xfer(0, 0);
        wait_done(0);

        // Reset mid-transfer, then a clean rerun
        start_xfer(0, 35);
        for (int k = 0; k < 60 && beats_seen < 5; k++) @(negedge clk);
        check("beats_before_reset", 32'(beats_seen >= 5), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        exp_q.delete();
        first_pending = 0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        start_xfer(0, 35);
        wait_done(35);

        // Randomized regions, lengths and consumer back-pressure
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 8; t++) begin
            int len;
            rdy_mode = $urandom_range(0, 2);
            len = (t == 0) ? 1100 : $urandom_range(1, 40);
            start_xfer($urandom_range(0, MEM_SIZE - 1), len);
            wait_done(len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
